dmem_port_arbiter: RTL and testbench

Registered two-requester arbiter that shares the single-ported data memory (byte/half/word access, separate MemRead/MemWrite strobes) between the instruction-fetch stage and the MEM stage of the pipelined RISC-V core. It accepts one command per cycle, drives the memory from a command register, and returns read data and an ack to the owning requester two cycles after acceptance. MEM-stage accesses have priority by default, and fetch stalls while it is denied. Misaligned data accesses are rejected with an error response and never reach the memory.

---
 rtl/dmem_arb_pkg.sv | 45 ++++
 rtl/dmem_arb_starve_cnt.sv | 38 +++
 rtl/dmem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: owner tags, access-size
// encoding, the pipelined command record and the alignment check.
package dmem_arb_pkg;

   localparam int CMD_AW = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   typedef logic [1:0] size_t;

   localparam size_t SZ_WORD = 2'd0;
   localparam size_t SZ_HALF = 2'd1;
   localparam size_t SZ_BYTE = 2'd2;

   typedef struct packed {
      logic [CMD_AW-1:0] addr;
      logic              we;
      logic              re;
      size_t             size;
      logic [31:0]       wdata;
      owner_e            owner;
      logic              err;
   } cmd_t;

   // Idle command: no strobes, no owner; also the reset value of stage B.
   localparam cmd_t CMD_IDLE = '{addr: '0, we: 1'b0, re: 1'b0, size: SZ_WORD,
                                 wdata: '0, owner: OWN_NONE, err: 1'b0};

   // Words need addr[1:0]==0, halves need addr[0]==0, bytes always fit.
   function automatic logic misaligned(input size_t size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      if (size == SZ_WORD) begin
         bad = (addr_lo != 2'b00);
      end else if (size == SZ_HALF) begin
         bad = addr_lo[0];
      end
      return bad;
   endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Fetch starvation counter: counts consecutive cycles in which fetch is
// requesting but data wins, and forces a fetch grant at STARVE_LIMIT.
// Only built when DMEM_ARB_ANTISTARVE_EN is defined.
module dmem_arb_starve_cnt #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic d_win,
   output logic force_if
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count denied fetch cycles (saturating); any other cycle clears the count.
   always_comb begin
      cnt_d = '0;
      if (if_req && d_win) begin
         cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
      end
   end

   // Counter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_if = if_req && (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter sharing the single-ported data memory between fetch
// and the MEM stage. Grant in stage A, memory access from the command
// register in stage B, response pulse to the owner in stage C.
// Optional: DMEM_ARB_ANTISTARVE_EN enables the fetch anti-starvation counter.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int AW           = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic          d_half,
   input  logic          d_byte,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   output logic          d_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_write,
   output logic          mem_read,
   output logic          mem_half,
   output logic          mem_byte,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   size_t       d_size;
   logic        d_misal;
   logic        force_if;
   logic        d_win;
   logic        if_win;
   logic        cmd_active;
   cmd_t        cmd_d, cmd_q;
   owner_e      rsp_owner_d, rsp_owner_q;
   logic [31:0] rsp_rdata_d, rsp_rdata_q;
   logic        rsp_err_d, rsp_err_q;

`ifdef DMEM_ARB_ANTISTARVE_EN
   dmem_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .d_win    (d_win),
      .force_if (force_if)
   );
`else
   // Strict data priority; the limit is only consulted with anti-starvation.
   assign force_if = 1'b0 && (STARVE_LIMIT > 0);
`endif

   // Size decode: byte dominates, so the illegal half+byte pair acts as byte.
   always_comb begin
      d_size = SZ_WORD;
      if (d_byte) begin
         d_size = SZ_BYTE;
      end else if (d_half) begin
         d_size = SZ_HALF;
      end
   end

   assign d_misal = misaligned(d_size, d_addr[1:0]);

   // Data wins unless fetch is being forced; no grants while in reset.
   assign d_win  = rst_n && d_req && !force_if;
   assign if_win = rst_n && if_req && !d_win;
   assign d_gnt  = d_win;
   assign if_gnt = if_win;

   // Stage A: build the command for the winner; misaligned data becomes an
   // idle command carrying the error tag so response order is kept.
   always_comb begin
      cmd_d = CMD_IDLE;
      if (d_win) begin
         cmd_d.owner = OWN_D;
         if (d_misal) begin
            cmd_d.err = 1'b1;
         end else begin
            cmd_d.addr  = CMD_AW'(d_addr);
            cmd_d.we    = d_we;
            cmd_d.re    = !d_we;
            cmd_d.size  = d_size;
            cmd_d.wdata = d_we ? d_wdata : 32'h0;
         end
      end else if (if_win) begin
         cmd_d.owner = OWN_IF;
         cmd_d.addr  = CMD_AW'(if_addr);
         cmd_d.re    = 1'b1;
         cmd_d.size  = SZ_WORD;
      end
   end

   // Command register feeding the memory in stage B.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q <= CMD_IDLE;
      end else begin
         cmd_q <= cmd_d;
      end
   end

   assign cmd_active = cmd_q.re || cmd_q.we;
   assign mem_addr   = cmd_q.addr[AW-1:0];
   assign mem_read   = cmd_q.re;
   assign mem_write  = cmd_q.we;
   assign mem_half   = cmd_active && (cmd_q.size == SZ_HALF);
   assign mem_byte   = cmd_active && (cmd_q.size == SZ_BYTE);
   assign mem_wdata  = cmd_q.wdata;

   // Stage B capture: read data only for loads, so stores and errors return 0.
   always_comb begin
      rsp_owner_d = cmd_q.owner;
      rsp_err_d   = cmd_q.err;
      rsp_rdata_d = cmd_q.re ? mem_rdata : 32'h0;
   end

   // Response register driving stage C.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_owner_q <= OWN_NONE;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
      end else begin
         rsp_owner_q <= rsp_owner_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign if_rvalid = (rsp_owner_q == OWN_IF);
   assign d_rvalid  = (rsp_owner_q == OWN_D);
   assign if_rdata  = if_rvalid ? rsp_rdata_q : 32'h0;
   assign d_rdata   = d_rvalid ? rsp_rdata_q : 32'h0;
   assign d_err     = d_rvalid && rsp_err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small byte-addressed memory
// model. Expectations adapt to DMEM_ARB_ANTISTARVE_EN when it is defined.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_ANTISTARVE_EN
   localparam bit ANTI = 1'b1;
`else
   localparam bit ANTI = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we, d_half, d_byte;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr;
   logic        mem_write, mem_read, mem_half, mem_byte;
   logic [31:0] mem_wdata, mem_rdata;

   int n_pass = 0;
   int n_total = 0;

   logic [7:0] mem [0:255];
   logic [7:0] ra;

   dmem_port_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_half(d_half), .d_byte(d_byte),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
      .mem_half(mem_half), .mem_byte(mem_byte), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: combinational zero-extended read, store at the clock edge.
   always_comb begin
      ra = mem_addr[7:0];
      if (mem_byte)      mem_rdata = {24'h0, mem[ra]};
      else if (mem_half) mem_rdata = {16'h0, mem[ra + 8'd1], mem[ra]};
      else               mem_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
   end

   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr[7:0]] <= mem_wdata[7:0];
         if (!mem_byte) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
         if (!mem_byte && !mem_half) begin
            mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
            mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic d_set(input logic req, input logic we, input logic half, input logic byt,
                        input logic [31:0] addr, input logic [31:0] wdata);
      d_req = req; d_we = we; d_half = half; d_byte = byt; d_addr = addr; d_wdata = wdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      rst_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h0;
      d_set(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset values, with both requests high to prove grants are held off.
      mid(); mid();
      chk("rst_if_gnt",    32'(if_gnt),    32'd0);
      chk("rst_d_gnt",     32'(d_gnt),     32'd0);
      chk("rst_mem_read",  32'(mem_read),  32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_addr",  mem_addr,       32'h0);
      chk("rst_mem_wdata", mem_wdata,      32'h0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_d_rvalid",  32'(d_rvalid),  32'd0);
      chk("rst_d_err",     32'(d_err),     32'd0);
      chk("rst_rdata",     if_rdata | d_rdata, 32'h0);
      $display("reset: state checked");
      cyc(); rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;
      cyc();

      // T1: fetch read of 0x10.
      cyc(); if_req = 1'b1; if_addr = 32'h10;
      mid(); chk("t1_if_gnt", 32'(if_gnt), 32'd1); chk("t1_d_gnt", 32'(d_gnt), 32'd0);
      cyc(); if_req = 1'b0;
      mid(); chk("t1_mem_read", 32'(mem_read), 32'd1); chk("t1_mem_addr", mem_addr, 32'h10);
             chk("t1_if_rvalid_early", 32'(if_rvalid), 32'd0);
      cyc();
      mid(); chk("t1_if_rvalid", 32'(if_rvalid), 32'd1); chk("t1_if_rdata", if_rdata, 32'h13121110);
             chk("t1_d_rvalid", 32'(d_rvalid), 32'd0);
      cyc();
      mid(); chk("t1_if_rvalid_pulse", 32'(if_rvalid), 32'd0);
      $display("T1 fetch read 0x10 done");

      // T2: word store 0xC against a simultaneous fetch of 0x20.
      cyc(); d_set(1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'hFF00FF00); if_req = 1'b1; if_addr = 32'h20;
      mid(); chk("t2_d_gnt", 32'(d_gnt), 32'd1); chk("t2_if_gnt_denied", 32'(if_gnt), 32'd0);
      cyc(); d_req = 1'b0; d_we = 1'b0;
      mid(); chk("t2_mem_write", 32'(mem_write), 32'd1); chk("t2_mem_addr", mem_addr, 32'hC);
             chk("t2_mem_wdata", mem_wdata, 32'hFF00FF00); chk("t2_if_gnt", 32'(if_gnt), 32'd1);
      cyc(); if_req = 1'b0;
      mid(); chk("t2_d_rvalid", 32'(d_rvalid), 32'd1); chk("t2_d_rdata", d_rdata, 32'h0);
             chk("t2_d_err", 32'(d_err), 32'd0); chk("t2_mem_write_once", 32'(mem_write), 32'd0);
             chk("t2_fetch_addr", mem_addr, 32'h20);
      cyc();
      mid(); chk("t2_if_rvalid", 32'(if_rvalid), 32'd1); chk("t2_if_rdata", if_rdata, 32'h23222120);
             chk("t2_d_rvalid_pulse", 32'(d_rvalid), 32'd0);
      $display("T2 word store 0xC then fetch 0x20 done");

      // T3: misaligned half load at 0x9.
      cyc(); d_set(1'b1, 1'b0, 1'b1, 1'b0, 32'h9, 32'h0);
      mid(); chk("t3_d_gnt", 32'(d_gnt), 32'd1);
      cyc(); d_req = 1'b0; d_half = 1'b0;
      mid(); chk("t3_no_strobe", {29'h0, mem_read, mem_write, mem_half}, 32'h0);
      cyc();
      mid(); chk("t3_d_rvalid", 32'(d_rvalid), 32'd1); chk("t3_d_err", 32'(d_err), 32'd1);
      cyc();
      mid(); chk("t3_d_err_pulse", 32'(d_err), 32'd0);
      $display("T3 misaligned half load 0x9 done");

      // T4: byte store 0xF0 @7, byte load @7, word load @0xC back to back.
      cyc(); d_set(1'b1, 1'b1, 1'b0, 1'b1, 32'h7, 32'h000000F0);
      mid(); chk("t4_st_gnt", 32'(d_gnt), 32'd1);
      cyc(); d_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h7, 32'h0);
      mid(); chk("t4_ld_gnt", 32'(d_gnt), 32'd1); chk("t4_mem_byte_wr", {30'h0, mem_write, mem_byte}, 32'h3);
             chk("t4_mem_addr", mem_addr, 32'h7);
      cyc(); d_set(1'b1, 1'b0, 1'b0, 1'b0, 32'hC, 32'h0);
      mid(); chk("t4_st_rsp", {31'h0, d_rvalid}, 32'h1); chk("t4_st_rdata", d_rdata, 32'h0);
      cyc(); d_req = 1'b0;
      mid(); chk("t4_ld_rvalid", 32'(d_rvalid), 32'd1); chk("t4_ld_rdata", d_rdata, 32'h000000F0);
      cyc();
      mid(); chk("t4_lw_rvalid", 32'(d_rvalid), 32'd1); chk("t4_lw_rdata", d_rdata, 32'hFF00FF00);
      cyc();
      $display("T4 byte store/load and word load done");

      // T5: both ports held high; fetch only gets in via anti-starvation.
      cyc(); d_set(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0); if_req = 1'b1; if_addr = 32'h40;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) cyc();
         mid();
         chk($sformatf("t5_if_gnt_%0d", i), 32'(if_gnt), 32'(ANTI && (i % 5 == 4)));
         chk($sformatf("t5_d_gnt_%0d", i),  32'(d_gnt),  32'(!(ANTI && (i % 5 == 4))));
      end
      cyc(); d_req = 1'b0; if_req = 1'b0; d_byte = 1'b0;
      cyc(); cyc(); cyc();
      $display("T5 starvation pattern done");

      // T6: reset asserted while a load sits in stage B.
      cyc(); d_set(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
      mid(); chk("t6_d_gnt", 32'(d_gnt), 32'd1);
      cyc();
      mid(); chk("t6_stage_b", 32'(mem_read), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_mem_read", 32'(mem_read), 32'd0);
      chk("t6_rst_mem_addr", mem_addr, 32'h0);
      chk("t6_rst_d_gnt",    32'(d_gnt),    32'd0);
      chk("t6_rst_rvalid",   {30'h0, if_rvalid, d_rvalid}, 32'h0);
      cyc(); d_req = 1'b0;
      cyc(); rst_n = 1'b1;
      mid(); chk("t6_post_rvalid0", {30'h0, if_rvalid, d_rvalid}, 32'h0); chk("t6_post_mem_read", 32'(mem_read), 32'd0);
      cyc();
      mid(); chk("t6_post_rvalid1", {30'h0, if_rvalid, d_rvalid}, 32'h0); chk("t6_post_d_rdata", d_rdata, 32'h0);
      $display("T6 reset during stage B done");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
